gpio_input_conditioner: RTL and testbench
=========================================

// Module: gpio_input_conditioner
// PURPOSE
//   Conditions raw board inputs (car sensors, pedestrian push-buttons) before they reach the
//   Avalon input PIO. Per channel: synchronise, correct polarity, debounce, and detect edges.
//   level_out drives the input PIO in_port directly.
//   Edge pulses and sticky event flags go to interrupt/capture logic.
// PARAMETERS
//   WIDTH            4      number of input channels
//   SYNC_STAGES      2      synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES  50000  consecutive stable samples needed to accept a change (>=2; 1 ms @ 50 MHz)
//   CNT_W            16     debounce counter width; must hold DEBOUNCE_CYCLES-1
//   ACTIVE_LOW       1      1: raw_in low means asserted (KEY buttons); 0: raw_in high means asserted
// PORTS
//   clk            in   1      system clock
//   reset_n        in   1      reset
//   raw_in         in   WIDTH  asynchronous board inputs
//   clear_events   in   WIDTH  per-channel clear strobe for event_latched
//   level_out      out  WIDTH  debounced logical level (1 = asserted); feeds PIO in_port
//   rise_pulse     out  WIDTH  1-cycle pulse when level_out goes 0->1
//   fall_pulse     out  WIDTH  1-cycle pulse when level_out goes 1->0
//   event_latched  out  WIDTH  sticky flag; set by rise, cleared by clear_events
// BEHAVIOUR
//   Clock/reset: reset reset_n, asynchronous, active-low; clock clk.
//   Reset values:
//   - level_out, rise_pulse, fall_pulse, event_latched: 0.
//   - Synchroniser flops: inactive raw level (ACTIVE_LOW ? 1 : 0).
//   - FSM: ST_LO. Counters: 0.
//   Polarity: s = sync_out ^ ACTIVE_LOW (s = logical level after synchronisation).
//   Per-channel FSM (all channels independent):
//   - ST_LO:   s=1 -> ST_PEND_HI, cnt<=1; else stay, cnt<=0.
//   - ST_PEND_HI:
//       s=0 -> ST_LO, cnt<=0 (glitch rejected, no output change).
//       s=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HI, level_out<=1, rise_pulse<=1, cnt<=0.
//       otherwise cnt<=cnt+1.
//   - ST_HI / ST_PEND_LO: mirror of the above with s inverted. Commit gives level_out<=0, fall_pulse<=1.
//   Latency: raw change held stable -> level_out change on clock edge SYNC_STAGES+DEBOUNCE_CYCLES.
//   Pulses are registered and high exactly one cycle, coincident with the level_out transition.
//   Bouncing input: any sample disagreeing with the pending level restarts the count.
//   - At most one pulse is emitted per accepted transition.
//   event_latched[i]:
//   - Set on rise_pulse[i].
//   - Cleared the cycle after clear_events[i]=1.
//   - Set and clear in the same cycle: set wins (no lost event).
//   Counter saturates by construction (never exceeds DEBOUNCE_CYCLES-1); no wrap possible.
//   Reset mid-operation forces all state to reset values immediately, with no pulse emitted.
//   - An input held asserted through reset is re-qualified afterwards.
//   - It then produces a rise_pulse SYNC_STAGES+DEBOUNCE_CYCLES edges after reset release.
//   No combinational path from any input to any output.
// TESTING (bench params: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1)
//   1 Reset, raw_in=4'hF, run 20 clks -> level_out=0, no pulses, event_latched=0 throughout.
//   2 raw_in[0] 1->0, held -> level_out[0]=1 on 10th edge; rise_pulse[0] high that single cycle;
//     event_latched[0]=1 next cycle.
//   3 raw_in[1] low for 7 clks then high -> no change on any output.
//     Then low for 8 clks -> level_out[1]=1 after 10 edges.
//     Then high again -> level_out[1]=0 after 10 edges, with fall_pulse[1].
//   4 raw_in[2] toggles every 3 clks for 30 clks, then settles low -> exactly one rise_pulse[2],
//     10 edges after settling.
//   5 clear_events[0] asserted in the same cycle as rise_pulse[0] -> event_latched[0] stays 1.
//     clear_events[0] alone later -> event_latched[0]=0 next cycle.
//   6 raw_in[3] low, reset_n pulsed low mid-count (cnt=5) -> all outputs 0 immediately.
//     After release, raw still low -> level_out[3]=1 on 10th edge after release.

Source files
------------

// File: rtl/gpio_input_conditioner_if.sv
// Board-input conditioner signal bundle: raw pins and clear strobes in, debounced level/edges/flags out.
// Combinational wiring only; the inputs are free-running, so there is no backpressure.
interface gpio_input_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clear_events;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] event_latched;

    modport master (
        output raw_in,
        output clear_events,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  event_latched
    );

    modport slave (
        input  raw_in,
        input  clear_events,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output event_latched
    );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-channel synchronise, polarity-correct, debounce and edge-detect of asynchronous board inputs.
// Raw change to level_out in SYNC_STAGES+DEBOUNCE_CYCLES edges; the inputs are free-running, so there is no backpressure.
module gpio_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    gpio_input_conditioner_if.slave   io
);

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_PEND_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] RAW_IDLE = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] event_q, event_d;
    logic [WIDTH-1:0] s;

    always_comb begin
        sync_d[0] = io.raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // s is the logical (asserted = 1) level seen by the debouncers
    assign s = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_LO: begin
                    if (s[i]) begin
                        state_d[i] = ST_PEND_HI;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                ST_PEND_HI: begin
                    if (!s[i]) begin
                        state_d[i] = ST_LO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = ST_HI;
                        level_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!s[i]) begin
                        state_d[i] = ST_PEND_LO;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                ST_PEND_LO: begin
                    if (s[i]) begin
                        state_d[i] = ST_HI;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = ST_LO;
                        level_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_LO;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // A rise and a clear landing together keep the flag set so no event is lost
    assign event_d = rise_q | (event_q & ~io.clear_events);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RAW_IDLE;
            end
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_LO;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            event_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
        end
    end

    assign io.level_out     = level_q;
    assign io.rise_pulse    = rise_q;
    assign io.fall_pulse    = fall_q;
    assign io.event_latched = event_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: expected edge events are queued at stimulus time and matched per cycle.
module tb_gpio_input_conditioner;

    localparam int W   = 4;
    localparam int LAT = 10;   // SYNC_STAGES + DEBOUNCE_CYCLES

    typedef struct {
        int cyc;
        int ch;
        bit rise;
    } exp_evt_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    exp_evt_t         sb[$];
    logic [W-1:0]     exp_level = '0;
    logic [W-1:0]     exp_rise, exp_fall;

    gpio_input_conditioner_if #(.WIDTH(W)) io ();

    gpio_input_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (16),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int at, input int ch, input bit rise);
        exp_evt_t e;
        e.cyc  = at;
        e.ch   = ch;
        e.rise = rise;
        sb.push_back(e);
    endtask

    // Monitor: pop every event due this cycle and compare pulses and level every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            exp_rise = '0;
            exp_fall = '0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].cyc == cyc) begin
                    if (sb[k].rise) exp_rise[sb[k].ch] = 1'b1;
                    else            exp_fall[sb[k].ch] = 1'b1;
                    sb.delete(k);
                end
            end
            if (!reset_n) exp_level = '0;
            else          exp_level = (exp_level | exp_rise) & ~exp_fall;
            check("rise_pulse", 32'(io.rise_pulse), 32'(exp_rise));
            check("fall_pulse", 32'(io.fall_pulse), 32'(exp_fall));
            check("level_out",  32'(io.level_out),  32'(exp_level));
        end
    end

    initial begin
        int t;
        io.raw_in       = 4'hF;
        io.clear_events = 4'h0;

        // Reset state, then idle with all inputs inactive
        tick(3);
        check("rst_level", 32'(io.level_out), 32'h0);
        check("rst_event", 32'(io.event_latched), 32'h0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_event", 32'(io.event_latched), 32'h0);
        end

        // Channel 0 press held
        t = cyc;
        io.raw_in[0] = 1'b0;
        expect_evt(t + LAT, 0, 1'b1);
        tick(LAT - 1);
        check("ch0_not_yet", 32'(io.level_out[0]), 32'h0);
        tick(1);
        check("ch0_rise_evt_same", 32'(io.event_latched[0]), 32'h0);
        tick(1);
        check("ch0_event_set", 32'(io.event_latched), 32'h1);

        // Channel 0 release, then clear its flag alone
        t = cyc;
        io.raw_in[0] = 1'b1;
        expect_evt(t + LAT, 0, 1'b0);
        tick(LAT + 2);
        check("ch0_event_sticky", 32'(io.event_latched[0]), 32'h1);
        io.clear_events[0] = 1'b1;
        tick(1);
        io.clear_events[0] = 1'b0;
        check("ch0_cleared", 32'(io.event_latched[0]), 32'h0);

        // Channel 1: 7-cycle glitch rejected, 8-cycle press accepted, then released
        io.raw_in[1] = 1'b0;
        tick(7);
        io.raw_in[1] = 1'b1;
        tick(15);
        check("ch1_glitch_level", 32'(io.level_out), 32'h0);
        t = cyc;
        io.raw_in[1] = 1'b0;
        expect_evt(t + LAT, 1, 1'b1);
        tick(8);
        io.raw_in[1] = 1'b1;
        expect_evt(t + 8 + LAT, 1, 1'b0);
        tick(2);
        check("ch1_level_hi", 32'(io.level_out[1]), 32'h1);
        tick(15);

        // Channel 2 bounces every 3 cycles, then settles asserted
        for (int i = 0; i < 10; i++) begin
            io.raw_in[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        t = cyc;
        io.raw_in[2] = 1'b0;
        expect_evt(t + LAT, 2, 1'b1);
        tick(LAT + 5);
        check("ch2_level_hi", 32'(io.level_out[2]), 32'h1);
        t = cyc;
        io.raw_in[2] = 1'b1;
        expect_evt(t + LAT, 2, 1'b0);
        tick(LAT + 2);

        // Clear coinciding with the rise pulse loses to the set
        t = cyc;
        io.raw_in[0] = 1'b0;
        expect_evt(t + LAT, 0, 1'b1);
        tick(LAT);
        check("ch0_rise_now", 32'(io.rise_pulse[0]), 32'h1);
        io.clear_events[0] = 1'b1;
        tick(1);
        io.clear_events[0] = 1'b0;
        check("set_beats_clear", 32'(io.event_latched[0]), 32'h1);
        tick(2);
        io.clear_events[0] = 1'b1;
        tick(1);
        io.clear_events[0] = 1'b0;
        check("clear_after_set", 32'(io.event_latched[0]), 32'h0);

        // Channel 3 press interrupted by reset mid-count; ch0 still held is re-qualified too
        io.raw_in[3] = 1'b0;
        tick(7);
        reset_n = 1'b0;
        #1;
        check("rst_mid_level", 32'(io.level_out), 32'h0);
        check("rst_mid_rise",  32'(io.rise_pulse), 32'h0);
        check("rst_mid_fall",  32'(io.fall_pulse), 32'h0);
        check("rst_mid_event", 32'(io.event_latched), 32'h0);
        tick(2);
        t = cyc;
        reset_n = 1'b1;
        expect_evt(t + LAT, 0, 1'b1);
        expect_evt(t + LAT, 3, 1'b1);
        tick(LAT - 1);
        check("post_rst_not_yet", 32'(io.level_out), 32'h0);
        tick(3);
        check("post_rst_level", 32'(io.level_out), 32'h9);
        check("post_rst_event", 32'(io.event_latched), 32'h9);

        tick(3);
        mon_en = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
